// File: rtl/drive_ctrl_pkg.sv
// Shared types for the drive session controller: state enum and state_o encodings.
package drive_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_REFUEL = 3'd2,
    S_DONE   = 3'd3,
    S_COOL   = 3'd4
  } drive_state_t;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_DRIVE  = 3'd1;
  localparam logic [2:0] ENC_REFUEL = 3'd2;
  localparam logic [2:0] ENC_DONE   = 3'd3;
  localparam logic [2:0] ENC_COOL   = 3'd4;

endpackage

// File: rtl/overheat_filter.sv
// Debounces the raw overheat sensor: hot asserts on the FILTER_CYCLES-th consecutive high sample.
module overheat_filter #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_overheated,
  output logic hot
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] SAT = CW'(FILTER_CYCLES);
  localparam logic [CW-1:0] THR = CW'(FILTER_CYCLES - 1);

  logic [CW-1:0] filt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               filt_cnt <= '0;
    else if (!cpu_overheated) filt_cnt <= '0;
    else if (filt_cnt != SAT) filt_cnt <= filt_cnt + 1'b1;
  end

  // Combinational on the current sample so the FSM reacts on the same edge.
  assign hot = cpu_overheated && (filt_cnt >= THR);

endmodule

// File: rtl/drive_session_controller.sv
// Trip sequencing FSM with refuel stops and debounced thermal shutdown.
// Optional drive-cycle statistics counter enabled by defining DRIVE_STATS_EN.
module drive_session_controller
  import drive_ctrl_pkg::*;
#(
  parameter int FILTER_CYCLES = 3,
  parameter int COOL_CYCLES   = 16,
  parameter int STAT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cpu_overheated,
  input  logic       arrived,
  input  logic       gas_tank_empty,
  input  logic       refuel_done,
  output logic       keep_driving,
  output logic       shut_off_computer,
  output logic [2:0] state_o,
  output logic       trip_done
`ifdef DRIVE_STATS_EN
  ,output logic [STAT_W-1:0] drive_cycles
`endif
);

  localparam int CCW = ($clog2(COOL_CYCLES) < 1) ? 1 : $clog2(COOL_CYCLES);
  localparam logic [CCW-1:0] COOL_LOAD = CCW'(COOL_CYCLES - 1);

  drive_state_t   state, next;
  logic           hot;
  logic [CCW-1:0] cool_cnt;

  overheat_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_overheated (cpu_overheated),
    .hot            (hot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE:   if (start) begin
                  if (arrived)             next = S_DONE;
                  else if (gas_tank_empty) next = S_REFUEL;
                  else                     next = S_DRIVE;
                end
      S_DRIVE:  if (arrived)             next = S_DONE;
                else if (gas_tank_empty) next = S_REFUEL;
      S_REFUEL: if (refuel_done && !gas_tank_empty) next = S_DRIVE;
      S_DONE:   if (!arrived) next = S_IDLE;
      S_COOL:   if (cool_cnt == '0 && !cpu_overheated) next = S_IDLE;
      default:  next = S_IDLE;
    endcase
    // Thermal override wins over every other transition.
    if (hot && state != S_COOL) next = S_COOL;
  end

  always_comb begin
    keep_driving      = (state == S_DRIVE);
    shut_off_computer = (state == S_COOL);
    state_o           = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cool_cnt <= '0;
    else if (state != S_COOL && next == S_COOL) cool_cnt <= COOL_LOAD;
    else if (state == S_COOL) begin
      if (cpu_overheated)        cool_cnt <= COOL_LOAD;
      else if (cool_cnt != '0)   cool_cnt <= cool_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trip_done <= 1'b0;
    else        trip_done <= (next == S_DONE) && (state != S_DONE);
  end

`ifdef DRIVE_STATS_EN
  // Cleared only when a start is actually taken (not pre-empted by overheat).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drive_cycles <= '0;
    else if (state == S_IDLE && start && !hot) drive_cycles <= '0;
    else if (state == S_DRIVE && drive_cycles != '1) drive_cycles <= drive_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_drive_session_controller.sv
// Directed table-driven bench for drive_session_controller plus multi-cycle corner sequences.
module tb_drive_session_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cpu_overheated, arrived, gas_tank_empty, refuel_done;
  logic       keep_driving, shut_off_computer, trip_done;
  logic [2:0] state_o;
`ifdef DRIVE_STATS_EN
  logic [15:0] drive_cycles;
  logic        kd4, so4, td4;
  logic [2:0]  st4;
  logic [3:0]  drive_cycles4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  drive_session_controller #(.FILTER_CYCLES(3), .COOL_CYCLES(16), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cpu_overheated(cpu_overheated),
    .arrived(arrived), .gas_tank_empty(gas_tank_empty), .refuel_done(refuel_done),
    .keep_driving(keep_driving), .shut_off_computer(shut_off_computer),
    .state_o(state_o), .trip_done(trip_done)
`ifdef DRIVE_STATS_EN
    , .drive_cycles(drive_cycles)
`endif
  );

`ifdef DRIVE_STATS_EN
  drive_session_controller #(.FILTER_CYCLES(3), .COOL_CYCLES(16), .STAT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .cpu_overheated(cpu_overheated),
    .arrived(arrived), .gas_tank_empty(gas_tank_empty), .refuel_done(refuel_done),
    .keep_driving(kd4), .shut_off_computer(so4),
    .state_o(st4), .trip_done(td4), .drive_cycles(drive_cycles4)
  );
`endif

  typedef struct {
    logic       st, ov, ar, em, rf;
    logic [2:0] e_state;
    logic       e_kd, e_so, e_td;
  } vec_t;

  function automatic vec_t mk(input logic st, ov, ar, em, rf,
                              input logic [2:0] es, input logic kd, so, td);
    vec_t v;
    v.st = st; v.ov = ov; v.ar = ar; v.em = em; v.rf = rf;
    v.e_state = es; v.e_kd = kd; v.e_so = so; v.e_td = td;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic st, ov, ar, em, rf);
    start = st; cpu_overheated = ov; arrived = ar; gas_tank_empty = em; refuel_done = rf;
  endtask

  vec_t vecs[23];
  int   n;
  logic td_seen;

  initial begin
    rst_n = 1'b0;
    drive_in(0, 0, 0, 0, 0);
    #2;
    check("reset_state", state_o, 0);
    check("reset_kd", keep_driving, 0);
    check("reset_so", shut_off_computer, 0);
    check("reset_td", trip_done, 0);
`ifdef DRIVE_STATS_EN
    check("reset_dc", drive_cycles, 0);
`endif
    #10 rst_n = 1'b1;

    //             st ov ar em rf  state kd so td
    vecs[0]  = mk(1, 0, 0, 0, 0,  1, 1, 0, 0);  // start -> DRIVE
    vecs[1]  = mk(1, 0, 0, 0, 0,  1, 1, 0, 0);  // start ignored in DRIVE
    vecs[2]  = mk(0, 0, 1, 0, 0,  3, 0, 0, 1);  // arrived -> DONE, pulse
    vecs[3]  = mk(1, 0, 1, 0, 0,  3, 0, 0, 0);  // hold DONE, pulse gone
    vecs[4]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0);  // -> IDLE
    vecs[5]  = mk(1, 0, 0, 1, 0,  2, 0, 0, 0);  // start with empty -> REFUEL
    vecs[6]  = mk(1, 0, 0, 1, 1,  2, 0, 0, 0);  // refuel_done while empty ignored
    vecs[7]  = mk(0, 0, 0, 0, 1,  1, 1, 0, 0);  // refilled -> DRIVE
    vecs[8]  = mk(0, 0, 0, 1, 0,  2, 0, 0, 0);  // empty -> REFUEL
    vecs[9]  = mk(0, 0, 0, 0, 1,  1, 1, 0, 0);
    vecs[10] = mk(0, 1, 0, 0, 0,  1, 1, 0, 0);  // 2-cycle overheat pulse
    vecs[11] = mk(0, 1, 0, 0, 0,  1, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0,  1, 1, 0, 0);
    vecs[13] = mk(0, 1, 0, 0, 0,  1, 1, 0, 0);  // another 2-cycle pulse
    vecs[14] = mk(0, 1, 0, 0, 0,  1, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0,  1, 1, 0, 0);
    vecs[16] = mk(0, 0, 1, 1, 0,  3, 0, 0, 1);  // arrived beats empty
    vecs[17] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[18] = mk(1, 0, 1, 0, 0,  3, 0, 0, 1);  // start with arrived -> DONE
    vecs[19] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[20] = mk(1, 1, 0, 0, 0,  1, 1, 0, 0);  // start, overheat 1
    vecs[21] = mk(0, 1, 0, 0, 0,  1, 1, 0, 0);  // overheat 2
    vecs[22] = mk(0, 1, 1, 1, 0,  4, 0, 1, 0);  // 3rd high beats arrived/empty

    for (int i = 0; i < 23; i++) begin
      drive_in(vecs[i].st, vecs[i].ov, vecs[i].ar, vecs[i].em, vecs[i].rf);
      step();
      check($sformatf("v%0d_state", i), state_o, vecs[i].e_state);
      check($sformatf("v%0d_kd", i), keep_driving, vecs[i].e_kd);
      check($sformatf("v%0d_so", i), shut_off_computer, vecs[i].e_so);
      check($sformatf("v%0d_td", i), trip_done, vecs[i].e_td);
    end

    // Cool-down with overheat dropping immediately: 16 cycles in COOL.
    drive_in(0, 0, 0, 0, 0);
    n = 0; td_seen = 0;
    while (state_o == 3'd4 && n < 40) begin
      step(); n++;
      td_seen |= trip_done;
    end
    check("cool_residency", n, 16);
    check("cool_exit_state", state_o, 0);
    check("cool_no_td", td_seen, 0);

    // Re-assert overheat at COOL cycle 10: reload, exit 16 cycles after drop.
    drive_in(1, 0, 0, 0, 0); step();
    check("s2_drive", state_o, 1);
    drive_in(0, 1, 0, 0, 0); step(); step();
    check("s2_pre_cool", state_o, 1);
    step();
    check("s2_cool", state_o, 4);
    drive_in(0, 0, 0, 0, 0);
    repeat (9) step();
    check("s2_cool_c9", state_o, 4);
    drive_in(0, 1, 0, 0, 0); step();
    check("s2_cool_c10", state_o, 4);
    drive_in(0, 0, 0, 0, 0);
    n = 0;
    while (state_o == 3'd4 && n < 40) begin
      step(); n++;
    end
    check("s2_reload_residency", n, 16);
    check("s2_exit_state", state_o, 0);

`ifdef DRIVE_STATS_EN
    drive_in(1, 0, 0, 0, 0); step();
    check("dc_cleared", drive_cycles, 0);
    drive_in(0, 0, 0, 0, 0);
    repeat (20) step();
    check("dc_20", drive_cycles, 20);
    check("dc4_sat", drive_cycles4, 15);
    drive_in(0, 0, 1, 0, 0); step();
    check("dc_done_state", state_o, 3);
    step();
    check("dc_hold", drive_cycles, 21);
    drive_in(0, 0, 0, 0, 0); step();
`endif

    // Asynchronous reset mid-DRIVE.
    drive_in(1, 0, 0, 0, 0); step();
    drive_in(0, 0, 0, 0, 0); step(); step();
    check("ar_pre_state", state_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_state", state_o, 0);
    check("ar_kd", keep_driving, 0);
    check("ar_so", shut_off_computer, 0);
    check("ar_td", trip_done, 0);
`ifdef DRIVE_STATS_EN
    check("ar_dc", drive_cycles, 0);
`endif
    step();
    rst_n = 1'b1;
    step();
    check("ar_post_state", state_o, 0);
    check("ar_post_td", trip_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
